neuron_result_tx: RTL

NEURON_RESULT_TX -- requirements
Module: neuron_result_tx

---
 rtl/neuron_result_tx.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/neuron_result_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : neuron_result_tx
//  Purpose  : Serialises three captured neuron results (sign/exponent/mantissa
//             packed into 12-bit words) onto a single UART-like line. Each word
//             is framed as start(0), 12 data bits MSB first, optional even
//             parity, stop(1). A one-deep pending buffer lets a new capture
//             queue behind the set currently on the wire.
//  Ports    : Clock        - single clock, rising edge
//             ResetN       - asynchronous active-low reset
//             Capture      - one-cycle pulse sampling the three results
//             SignInN      - result sign (N = 0..2)
//             ExponentInN  - 5-bit result exponent
//             MantissaInN  - 6-bit result mantissa
//             ClearErr     - clears the sticky Overrun flag
//             TxLine       - registered serial output, idles high
//             Busy         - high while a frame set is transmitting
//             Done         - one-cycle pulse at the end of the third word
//             Overrun      - sticky, set when a capture had to be dropped
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_result_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       Capture,
    input  logic       SignIn0,
    input  logic       SignIn1,
    input  logic       SignIn2,
    input  logic [4:0] ExponentIn0,
    input  logic [4:0] ExponentIn1,
    input  logic [4:0] ExponentIn2,
    input  logic [5:0] MantissaIn0,
    input  logic [5:0] MantissaIn1,
    input  logic [5:0] MantissaIn2,
    input  logic       ClearErr,
    output logic       TxLine,
    output logic       Busy,
    output logic       Done,
    output logic       Overrun
);

    localparam logic [7:0] c_lastTick = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      r_state, w_nextState;
    logic [7:0]  r_clkCnt, w_clkCnt;
    logic [3:0]  r_bitIdx, w_bitIdx;
    logic [1:0]  r_wordIdx, w_wordIdx;
    logic [11:0] r_shift, w_shift;
    // Three words packed as {word0, word1, word2}
    logic [35:0] r_hold, w_hold;
    logic [35:0] r_pend, w_pend;
    logic        r_pendValid, w_pendValid;
    logic        r_txLine, w_txLine;
    logic        r_done, w_done;
    logic        r_overrun, w_overrun;

    logic [35:0] w_capData;
    logic [11:0] w_curWord;
    logic        w_bitEnd;
    logic        w_setEnd;
    logic        w_ovEvent;

    assign w_capData = {SignIn0, ExponentIn0, MantissaIn0,
                        SignIn1, ExponentIn1, MantissaIn1,
                        SignIn2, ExponentIn2, MantissaIn2};

    always_comb begin
        case (r_wordIdx)
            2'd0:    w_curWord = r_hold[35:24];
            2'd1:    w_curWord = r_hold[23:12];
            default: w_curWord = r_hold[11:0];
        endcase
    end

    assign w_bitEnd = (r_clkCnt == c_lastTick);
    // Last cycle of the last stop bit of the set
    assign w_setEnd = (r_state == STOP) && w_bitEnd && (r_wordIdx == 2'd2);

    // State register
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        w_nextState = r_state;
        w_clkCnt    = r_clkCnt;
        w_bitIdx    = r_bitIdx;
        w_wordIdx   = r_wordIdx;
        w_shift     = r_shift;
        w_hold      = r_hold;
        w_pend      = r_pend;
        w_pendValid = r_pendValid;
        w_txLine    = r_txLine;
        w_done      = 1'b0;
        w_ovEvent   = 1'b0;

        if (r_state != IDLE) begin
            w_clkCnt = w_bitEnd ? 8'd0 : r_clkCnt + 8'd1;
        end

        case (r_state)
            IDLE: begin
                if (Capture) begin
                    w_hold      = w_capData;
                    w_nextState = START;
                    w_txLine    = 1'b0;
                    w_clkCnt    = 8'd0;
                    w_wordIdx   = 2'd0;
                end
            end
            START: begin
                if (w_bitEnd) begin
                    w_nextState = DATA;
                    w_bitIdx    = 4'd11;
                    w_txLine    = w_curWord[11];
                    w_shift     = {w_curWord[10:0], 1'b0};
                end
            end
            DATA: begin
                if (w_bitEnd) begin
                    if (r_bitIdx == 4'd0) begin
                        if (PARITY_EN != 0) begin
                            w_nextState = PARITY;
                            w_txLine    = ^w_curWord;
                        end else begin
                            w_nextState = STOP;
                            w_txLine    = 1'b1;
                        end
                    end else begin
                        w_bitIdx = r_bitIdx - 4'd1;
                        w_txLine = r_shift[11];
                        w_shift  = {r_shift[10:0], 1'b0};
                    end
                end
            end
            PARITY: begin
                if (w_bitEnd) begin
                    w_nextState = STOP;
                    w_txLine    = 1'b1;
                end
            end
            STOP: begin
                if (w_bitEnd) begin
                    if (r_wordIdx != 2'd2) begin
                        w_wordIdx   = r_wordIdx + 2'd1;
                        w_nextState = START;
                        w_txLine    = 1'b0;
                    end else begin
                        w_done = 1'b1;
                        if (r_pendValid) begin
                            // Queued set goes straight out; a simultaneous
                            // capture finds the buffer still full and is lost.
                            w_hold      = r_pend;
                            w_pendValid = 1'b0;
                            w_nextState = START;
                            w_txLine    = 1'b0;
                            w_wordIdx   = 2'd0;
                            w_ovEvent   = Capture;
                        end else if (Capture) begin
                            // Capture landing on the final stop edge takes the
                            // pending slot, which is consumed at once.
                            w_hold      = w_capData;
                            w_nextState = START;
                            w_txLine    = 1'b0;
                            w_wordIdx   = 2'd0;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_txLine    = 1'b1;
            end
        endcase

        // Capture during a set (other than its final edge) targets the buffer
        if (Capture && (r_state != IDLE) && !w_setEnd) begin
            if (r_pendValid) begin
                w_ovEvent = 1'b1;
            end else begin
                w_pend      = w_capData;
                w_pendValid = 1'b1;
            end
        end

        // A new drop wins over a simultaneous clear
        if (w_ovEvent) begin
            w_overrun = 1'b1;
        end else if (ClearErr) begin
            w_overrun = 1'b0;
        end else begin
            w_overrun = r_overrun;
        end
    end

    // Datapath registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_clkCnt    <= 8'd0;
            r_bitIdx    <= 4'd0;
            r_wordIdx   <= 2'd0;
            r_shift     <= 12'd0;
            r_hold      <= 36'd0;
            r_pend      <= 36'd0;
            r_pendValid <= 1'b0;
            r_txLine    <= 1'b1;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_clkCnt    <= w_clkCnt;
            r_bitIdx    <= w_bitIdx;
            r_wordIdx   <= w_wordIdx;
            r_shift     <= w_shift;
            r_hold      <= w_hold;
            r_pend      <= w_pend;
            r_pendValid <= w_pendValid;
            r_txLine    <= w_txLine;
            r_done      <= w_done;
            r_overrun   <= w_overrun;
        end
    end

    assign TxLine  = r_txLine;
    assign Busy    = (r_state != IDLE);
    assign Done    = r_done;
    assign Overrun = r_overrun;

endmodule
`default_nettype wire
